// File: rtl/async_fifo_param.sv
// Dual-clock FIFO with Gray-coded pointer crossing, threshold flags,
// per-domain occupancy, sticky error flags and optional FWFT read port.
module async_fifo_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH   = 2,
  parameter bit FWFT        = 1'b0
) (
  input  logic                  write_clk,
  input  logic                  write_reset_n,
  input  logic                  read_clk,
  input  logic                  read_reset_n,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow
);

  localparam int AW    = ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;

  typedef logic [AW:0] ptr_t;

  localparam ptr_t AF_T      = ptr_t'(AF_THRESH);
  localparam ptr_t AE_T      = ptr_t'(AE_THRESH);
  localparam ptr_t FULL_MASK = ptr_t'(3) << (AW - 1);

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  ptr_t wbin, wgray, wbin_next, wgray_next;
  ptr_t rbin, rgray, rbin_next, rgray_next;
  ptr_t rsync_bin, wsync_bin;
  logic [SYNC_STAGES-1:0][AW:0] rq;
  logic [SYNC_STAGES-1:0][AW:0] wq;

  logic wr_accept;
  logic rd_fetch;
  logic pop;
  logic arr_empty;
  logic rv_q;
  ptr_t rd_extra;

  // Write domain
  assign wr_accept  = write_en && !full;
  assign wbin_next  = wbin + ptr_t'(wr_accept);
  assign wgray_next = bin2gray(wbin_next);
  assign rsync_bin  = gray2bin(rq[SYNC_STAGES-1]);

  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      rq <= '0;
    end else begin
      rq <= {rq[SYNC_STAGES-2:0], rgray};
    end
  end

  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      wbin     <= '0;
      wgray    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wbin     <= wbin_next;
      wgray    <= wgray_next;
      full     <= (wgray_next == (rq[SYNC_STAGES-1] ^ FULL_MASK));
      overflow <= overflow || (write_en && full);
    end
  end

  always_ff @(posedge write_clk) begin
    if (wr_accept) begin
      mem[wbin[AW-1:0]] <= write_data;
    end
  end

  assign wr_count    = wbin - rsync_bin;
  assign almost_full = (wr_count >= AF_T);

  // Read domain
  always_comb begin
    pop      = read_en && rv_q;
    rd_fetch = 1'b0;
    if (FWFT) begin
      rd_fetch = !arr_empty && (!rv_q || pop);
    end else begin
      rd_fetch = read_en && !arr_empty;
    end
  end

  assign rbin_next  = rbin + ptr_t'(rd_fetch);
  assign rgray_next = bin2gray(rbin_next);
  assign wsync_bin  = gray2bin(wq[SYNC_STAGES-1]);

  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      wq <= '0;
    end else begin
      wq <= {wq[SYNC_STAGES-2:0], wgray};
    end
  end

  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      rbin      <= '0;
      rgray     <= '0;
      arr_empty <= 1'b1;
      rv_q      <= 1'b0;
      read_data <= '0;
      underflow <= 1'b0;
    end else begin
      rbin      <= rbin_next;
      rgray     <= rgray_next;
      arr_empty <= (rgray_next == wq[SYNC_STAGES-1]);
      // FWFT keeps the head word until popped; standard mode pulses
      rv_q      <= FWFT ? (rd_fetch || (rv_q && !pop)) : rd_fetch;
      if (rd_fetch) begin
        read_data <= mem[rbin[AW-1:0]];
      end
      underflow <= underflow || (read_en && empty);
    end
  end

  assign read_valid   = rv_q;
  assign empty        = FWFT ? !rv_q : arr_empty;
  assign rd_extra     = FWFT ? ptr_t'(rv_q) : '0;
  assign rd_count     = wsync_bin - rbin + rd_extra;
  assign almost_empty = (rd_count <= AE_T);

endmodule

// File: tb/tb_async_fifo_param.sv
// Scoreboard bench for async_fifo_param: standard-mode instance
// under directed and random traffic, plus an FWFT instance.
module tb_async_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int SS    = 2;
  localparam int DEPTH = 8;

  logic write_clk = 1'b0;
  logic read_clk  = 1'b0;
  logic write_reset_n = 1'b0;
  logic read_reset_n  = 1'b0;

  always #5 write_clk = ~write_clk;
  always #7 read_clk  = ~read_clk;

  logic          write_en = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic          read_en = 1'b0;
  logic          full, almost_full, overflow;
  logic [AW:0]   wr_count, rd_count;
  logic [DW-1:0] read_data;
  logic          read_valid, empty, almost_empty, underflow;

  logic          f_write_en = 1'b0;
  logic [DW-1:0] f_write_data = '0;
  logic          f_read_en = 1'b0;
  logic          f_full, f_almost_full, f_overflow;
  logic [AW:0]   f_wr_count, f_rd_count;
  logic [DW-1:0] f_read_data;
  logic          f_read_valid, f_empty, f_almost_empty, f_underflow;

  async_fifo_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SS),
    .AF_THRESH(DEPTH-2), .AE_THRESH(2), .FWFT(1'b0)
  ) dut (
    .write_clk(write_clk), .write_reset_n(write_reset_n),
    .read_clk(read_clk), .read_reset_n(read_reset_n),
    .write_en(write_en), .write_data(write_data),
    .full(full), .almost_full(almost_full),
    .wr_count(wr_count), .overflow(overflow),
    .read_en(read_en), .read_data(read_data),
    .read_valid(read_valid), .empty(empty),
    .almost_empty(almost_empty), .rd_count(rd_count),
    .underflow(underflow)
  );

  async_fifo_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SS),
    .AF_THRESH(DEPTH-2), .AE_THRESH(2), .FWFT(1'b1)
  ) dut_f (
    .write_clk(write_clk), .write_reset_n(write_reset_n),
    .read_clk(read_clk), .read_reset_n(read_reset_n),
    .write_en(f_write_en), .write_data(f_write_data),
    .full(f_full), .almost_full(f_almost_full),
    .wr_count(f_wr_count), .overflow(f_overflow),
    .read_en(f_read_en), .read_data(f_read_data),
    .read_valid(f_read_valid), .empty(f_empty),
    .almost_empty(f_almost_empty), .rd_count(f_rd_count),
    .underflow(f_underflow)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int occ = 0;
  logic [DW-1:0] model[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: every standard-mode read_valid pops the scoreboard
  always @(negedge read_clk) begin
    if (read_reset_n && read_valid) begin
      if (model.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected: got %0h, expected no word", read_data);
      end else begin
        check("rd_data", read_data, model.pop_front());
      end
    end
  end

  task automatic wr_edge();
    @(posedge write_clk);
    #1;
  endtask

  task automatic rd_edge();
    @(posedge read_clk);
    #1;
  endtask

  task automatic check_reset(input string t);
    check({t, "_full"}, full, 0);
    check({t, "_afull"}, almost_full, 0);
    check({t, "_wrcnt"}, wr_count, 0);
    check({t, "_ovf"}, overflow, 0);
    check({t, "_empty"}, empty, 1);
    check({t, "_aempty"}, almost_empty, 1);
    check({t, "_rdcnt"}, rd_count, 0);
    check({t, "_rvalid"}, read_valid, 0);
    check({t, "_rdata"}, read_data, 0);
    check({t, "_unf"}, underflow, 0);
    check({t, "_f_empty"}, f_empty, 1);
    check({t, "_f_rvalid"}, f_read_valid, 0);
  endtask

  task automatic do_read(input string tag);
    int t;
    t = 0;
    rd_edge();
    while (empty && t < 40) begin
      rd_edge();
      t++;
    end
    if (empty) begin
      fail_now(tag);
    end else begin
      read_en = 1'b1;
      rd_edge();
      read_en = 1'b0;
      check({tag, "_latency"}, read_valid, 1);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH && occ > 0; k++) begin
      do_read("drain");
      occ--;
    end
    repeat (2) rd_edge();
    check("sb_drained", model.size(), 0);
  endtask

  task automatic write_burst(input int n);
    wr_edge();
    write_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      write_data = DW'(i * 8'h11);
      model.push_back(write_data);
      wr_edge();
    end
    write_en = 1'b0;
  endtask

  task automatic traffic(input int wp, input int rp,
                         input int wn, input int rn);
    fork
      begin
        for (int i = 0; i < wn; i++) begin
          wr_edge();
          write_en = 1'b0;
          if (!full && $urandom_range(99) < wp) begin
            check("full_not_optimistic", occ < DEPTH, 1);
            write_en = 1'b1;
            write_data = DW'($urandom);
            model.push_back(write_data);
            occ++;
          end
        end
        wr_edge();
        write_en = 1'b0;
      end
      begin
        for (int j = 0; j < rn; j++) begin
          rd_edge();
          read_en = 1'b0;
          if (!empty && $urandom_range(99) < rp) begin
            check("empty_not_optimistic", occ > 0, 1);
            read_en = 1'b1;
            occ--;
          end
        end
        rd_edge();
        read_en = 1'b0;
      end
    join
  endtask

  initial begin
    int t;
    repeat (5) @(posedge read_clk);
    #1;
    check_reset("rst0");
    @(negedge read_clk);
    write_reset_n = 1'b1;
    read_reset_n  = 1'b1;
    repeat (3) rd_edge();

    // Fill to full, then an overflowing write
    write_burst(DEPTH);
    check("fill_full", full, 1);
    check("fill_wrcnt", wr_count, DEPTH);
    check("fill_afull", almost_full, 1);
    repeat (SS + 1) rd_edge();
    check("fill_rdcnt", rd_count, DEPTH);
    check("fill_empty", empty, 0);
    check("fill_aempty", almost_empty, 0);
    wr_edge();
    write_en = 1'b1;
    write_data = 8'h88;
    wr_edge();
    write_en = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_wrcnt", wr_count, DEPTH);

    // Drain in order, then an underflowing read
    occ = DEPTH;
    drain();
    check("drain_empty", empty, 1);
    check("drain_aempty", almost_empty, 1);
    check("drain_rdcnt", rd_count, 0);
    repeat (SS + 1) wr_edge();
    check("drain_full_rel", full, 0);
    check("drain_wrcnt", wr_count, 0);
    rd_edge();
    read_en = 1'b1;
    rd_edge();
    read_en = 1'b0;
    check("unf_set", underflow, 1);
    check("unf_rdata", read_data, 8'h77);
    check("unf_rvalid", read_valid, 0);

    // FWFT head word appears without read_en
    wr_edge();
    f_write_en = 1'b1;
    f_write_data = 8'hA5;
    wr_edge();
    f_write_en = 1'b0;
    t = 0;
    while (!f_read_valid && t < 10) begin
      rd_edge();
      t++;
    end
    check("fwft_latency_ok", t <= SS + 2, 1);
    check("fwft_valid", f_read_valid, 1);
    check("fwft_data", f_read_data, 8'hA5);
    check("fwft_empty", f_empty, 0);
    check("fwft_rdcnt", f_rd_count, 1);
    f_read_en = 1'b1;
    rd_edge();
    f_read_en = 1'b0;
    check("fwft_pop_valid", f_read_valid, 0);
    check("fwft_pop_empty", f_empty, 1);
    check("fwft_pop_rdcnt", f_rd_count, 0);
    check("fwft_unf", f_underflow, 0);

    // Reset with words stored discards them
    write_burst(5);
    repeat (SS + 1) rd_edge();
    check("pre_rst_rdcnt", rd_count, 5);
    @(negedge write_clk);
    write_reset_n = 1'b0;
    read_reset_n  = 1'b0;
    #1;
    check_reset("rst1");
    model.delete();
    repeat (4) @(posedge read_clk);
    @(negedge read_clk);
    write_reset_n = 1'b1;
    read_reset_n  = 1'b1;
    repeat (2) rd_edge();
    wr_edge();
    write_en = 1'b1;
    write_data = 8'h3C;
    model.push_back(8'h3C);
    wr_edge();
    write_en = 1'b0;
    occ = 1;
    drain();
    check("post_rst_empty", empty, 1);

    // Random mixed traffic
    occ = 0;
    traffic(70, 75, 200, 200);
    repeat (SS + 1) wr_edge();
    check("rand_wrcnt", wr_count, occ);
    repeat (SS + 1) rd_edge();
    check("rand_rdcnt", rd_count, occ);
    check("rand_ovf", overflow, 0);
    check("rand_unf", underflow, 0);
    drain();

    // Continuous read and write starting at occupancy 4
    write_burst(4);
    repeat (SS + 1) rd_edge();
    occ = 4;
    check("cont_rdcnt", rd_count, 4);
    traffic(100, 100, 70, 50);
    check("cont_ovf", overflow, 0);
    check("cont_unf", underflow, 0);
    drain();
    check("end_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/async_fifo_param.md
# async_fifo_param

Parametrised dual-clock FIFO for moving data words between unrelated write and read clock domains. It uses Gray-coded pointers with configurable synchroniser depth, exposes programmable almost-full/almost-empty flags, per-domain occupancy counts and sticky overflow/underflow flags. An optional first-word-fall-through (FWFT) read mode is selectable at elaboration time. It replaces the fixed-feature async FIFO in new designs.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (always a power of two)
- SYNC_STAGES, 2, flops per pointer synchroniser, legal range 2..4
- AF_THRESH, DEPTH-2, almost_full asserts when wr_count >= AF_THRESH
- AE_THRESH, 2, almost_empty asserts when rd_count <= AE_THRESH
- FWFT, 0, 0 = registered standard read; 1 = first-word-fall-through

- write_clk  in  1  write-domain clock
- write_reset_n  in  1  write-domain reset, asynchronous, active-low
- read_clk  in  1  read-domain clock
- read_reset_n  in  1  read-domain reset, asynchronous, active-low
- write_en  in  1  write request
- write_data  in  DATA_WIDTH  word to write
- full  out  1  no free entry (write domain)
- almost_full  out  1  occupancy threshold flag (write domain)
- wr_count  out  ADDR_WIDTH+1  occupancy seen from the write domain
- overflow  out  1  sticky: write_en while full
- read_en  in  1  read request (standard mode) or pop (FWFT)
- read_data  out  DATA_WIDTH  output word, registered
- read_valid  out  1  read_data holds a popped/head word
- empty  out  1  no word available (read domain)
- almost_empty  out  1  occupancy threshold flag (read domain)
- rd_count  out  ADDR_WIDTH+1  occupancy seen from the read domain
- underflow  out  1  sticky: read_en while empty

## Operation
- Storage: DEPTH x DATA_WIDTH array, written on write_clk and read on read_clk.
- Pointers: binary and Gray, each ADDR_WIDTH+1 bits. The extra MSB is the wrap bit. Each Gray pointer crosses into the other domain through a SYNC_STAGES flop chain and is converted back to binary there.
- Accepted write = write_en && !full: array[wptr] <= write_data, wptr increments modulo 2**(ADDR_WIDTH+1).
- full: next Gray wptr equals synchronised Gray rptr with its top two bits inverted. full is registered.
- empty (standard mode): Gray rptr equals synchronised Gray wptr. empty is registered.
- wr_count = wptr_bin - rptr_sync_bin, and rd_count = wptr_sync_bin - rptr_bin, both modulo 2**(ADDR_WIDTH+1). A count of DEPTH is legal.
- Standard mode: an accepted read (read_en && !empty) loads read_data from the array and pulses read_valid high for one cycle on the next read_clk edge. read_data holds its value otherwise.
- FWFT mode: a one-entry output register prefetches the array head whenever it is empty or being popped.
  - read_valid = output register occupied, and empty = !read_valid.
  - read_en && read_valid pops the register.
  - rd_count includes the output register.
- Write while full: the write is dropped, no state changes, overflow is set.
- Read while empty: the read is dropped, underflow is set. The sticky flags clear only on their own domain reset.
- Simultaneous read and write at any occupancy is legal. Each side updates only its own pointer.

## Timing
- Write-domain reset values: full 0, almost_full 0, wr_count 0, overflow 0, wptr 0.
- Read-domain reset values: empty 1, almost_empty 1, rd_count 0, read_valid 0, read_data 0, underflow 0, rptr 0.
- Both resets must be asserted together and overlap by at least SYNC_STAGES+1 cycles of the slower clock. Reset mid-operation discards all contents. A one-sided reset is unsupported, but outputs must still never go X.
- Write-to-read visibility: a word accepted at write_clk edge k clears empty SYNC_STAGES+1 read_clk edges later. In FWFT mode, read_valid rises one read_clk after that.
- Read-to-full release: full deasserts SYNC_STAGES+1 write_clk edges after the freeing read.
- Standard read latency is 1 read_clk from the accepting edge to read_data/read_valid.
- Flags are pessimistic: full and almost_full may stay high, and empty and almost_empty may stay high, for up to SYNC_STAGES+1 extra cycles. They are never optimistic.
- Pointer wrap: after 2*DEPTH accepted writes, wptr returns to 0 with no glitch on the flags.

## Test plan
1. Setup for all scenarios: ADDR_WIDTH=3, write_clk 10 ns, read_clk 14 ns. Write 8 words 0x00,0x11..0x77 back-to-back -> full=1 and wr_count=8. After SYNC_STAGES+1 read clocks, rd_count=8 and almost_full=1 from wr_count>=6. A 9th write -> dropped and overflow=1.
2. Drain all 8 words in standard mode -> read_data sequence 0x00..0x77, each one read_clk after its accept. Then empty=1 and almost_empty=1. An extra read_en -> underflow=1 and read_data unchanged.
3. Random mixed traffic for 200 iterations, crossing at least 3 pointer wraps -> scoreboard order matches exactly. Final wr_count equals scoreboard occupancy after 3 write clocks.
4. FWFT=1: write 0xA5 -> read_valid=1 and read_data=0xA5 with no read_en, within SYNC_STAGES+2 read clocks. Pulse read_en -> read_valid=0 and empty=1.
5. Assert both resets with 5 words stored -> on the reset edge all outputs take their reset values. After release, write 0x3C then read -> 0x3C returned, with no stale data.
6. Hold write_en and read_en continuously at occupancy 4 for 50 cycles -> no overflow or underflow, and the data order is preserved.
